// File: rtl/cache_fill_ctrl_if.sv
// Bus bundle between the cache fill controller and its environment.
// Carries the request/response handshake, the backing-memory request and
// response channel, and the dual-port cache connections (A = write, B = read).
//   slave  : controller side (cache_fill_ctrl)
//   master : environment side (requester, memory, cache)
interface cache_fill_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  // request / response
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  req_we_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [DATA_WIDTH-1:0] resp_data_o;
  // backing memory
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic [ADDR_WIDTH-1:0] mem_req_addr_o;
  logic                  mem_req_we_o;
  logic [DATA_WIDTH-1:0] mem_req_wdata_o;
  logic                  mem_rsp_valid_i;
  logic [DATA_WIDTH-1:0] mem_rsp_data_i;
  // cache ports
  logic [ADDR_WIDTH-1:0] cache_addra_o;
  logic [ADDR_WIDTH-1:0] cache_addrb_o;
  logic [DATA_WIDTH-1:0] cache_wdata_o;
  logic                  cache_cea_o;
  logic                  cache_ceb_o;
  logic                  cache_we_o;
  logic [DATA_WIDTH-1:0] cache_rdatab_i;
  logic                  cache_rhitb_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, resp_ready_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
           cache_rdatab_i, cache_rhitb_i,
    output req_ready_o, resp_valid_o, resp_data_o,
           mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o,
           cache_addra_o, cache_addrb_o, cache_wdata_o,
           cache_cea_o, cache_ceb_o, cache_we_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, resp_ready_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
           cache_rdatab_i, cache_rhitb_i,
    input  req_ready_o, resp_valid_o, resp_data_o,
           mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o,
           cache_addra_o, cache_addrb_o, cache_wdata_o,
           cache_cea_o, cache_ceb_o, cache_we_o
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Request-side controller for a direct-mapped dual-port cache.
// Single-word read/write requests are probed on cache port B; read hits are
// answered from the cache, read misses are fetched from backing memory and
// filled through port A. Writes are write-allocate, write-through.
// Per-line valid bits qualify the cache's tag match, which alone would hit on
// stale reset contents.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   flush_i          pulse: invalidate all lines (deferred to IDLE if busy)
//   hit_count_o      saturating read-hit count
//   miss_count_o     saturating read-miss count
//   bus              request/response, memory and cache signals (slave side)
module cache_fill_ctrl #(
  parameter int unsigned IDX_BITS   = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush_i,
  output logic [CNT_WIDTH-1:0] hit_count_o,
  output logic [CNT_WIDTH-1:0] miss_count_o,
  cache_fill_ctrl_if.slave     bus
);
  localparam int unsigned LINES = 2 ** IDX_BITS;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT,
    RESP
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [LINES-1:0]      valid_q;
  logic                  flush_pend;
  logic [CNT_WIDTH-1:0]  hit_cnt;
  logic [CNT_WIDTH-1:0]  miss_cnt;

  logic [IDX_BITS-1:0]   idx;
  logic                  flush_req;
  logic                  hit;
  logic                  fill;

  assign idx       = addr_q[IDX_BITS-1:0];
  // A flush requested now or earlier blocks acceptance in IDLE.
  assign flush_req = flush_i | flush_pend;
  assign hit       = bus.cache_rhitb_i & valid_q[idx];
  assign fill      = (state == MEM_WAIT) && bus.mem_rsp_valid_i;

  assign hit_count_o     = hit_cnt;
  assign miss_count_o    = miss_cnt;
  assign bus.resp_data_o = data_q;

  always_comb begin
    state_nxt           = state;
    bus.req_ready_o     = 1'b0;
    bus.resp_valid_o    = 1'b0;
    bus.mem_req_valid_o = 1'b0;
    bus.mem_req_addr_o  = '0;
    bus.mem_req_we_o    = 1'b0;
    bus.mem_req_wdata_o = '0;
    bus.cache_addra_o   = '0;
    bus.cache_addrb_o   = '0;
    bus.cache_wdata_o   = '0;
    bus.cache_cea_o     = 1'b0;
    bus.cache_ceb_o     = 1'b0;
    bus.cache_we_o      = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready_o = ~flush_req;
        if (bus.req_valid_i && !flush_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        bus.cache_ceb_o   = 1'b1;
        bus.cache_addrb_o = addr_q;
        if (we_q) begin
          bus.cache_cea_o   = 1'b1;
          bus.cache_we_o    = 1'b1;
          bus.cache_addra_o = addr_q;
          bus.cache_wdata_o = wdata_q;
          state_nxt         = MEM_REQ;
        end else if (hit) begin
          state_nxt = RESP;
        end else begin
          state_nxt = MEM_REQ;
        end
      end
      MEM_REQ: begin
        bus.mem_req_valid_o = 1'b1;
        bus.mem_req_addr_o  = addr_q;
        bus.mem_req_we_o    = we_q;
        bus.mem_req_wdata_o = wdata_q;
        if (bus.mem_req_ready_i) state_nxt = we_q ? RESP : MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.mem_rsp_valid_i) begin
          bus.cache_cea_o   = 1'b1;
          bus.cache_we_o    = 1'b1;
          bus.cache_addra_o = addr_q;
          bus.cache_wdata_o = bus.mem_rsp_data_i;
          state_nxt         = RESP;
        end
      end
      RESP: begin
        bus.resp_valid_o = 1'b1;
        if (bus.resp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      data_q     <= '0;
      valid_q    <= '0;
      flush_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state <= state_nxt;

      // Flush executes only in IDLE; elsewhere it is remembered so an
      // in-flight fill completes first and is then invalidated.
      if (state == IDLE) begin
        if (flush_req) begin
          valid_q    <= '0;
          flush_pend <= 1'b0;
        end else if (bus.req_valid_i) begin
          addr_q  <= bus.req_addr_i;
          we_q    <= bus.req_we_i;
          wdata_q <= bus.req_wdata_i;
        end
      end else if (flush_i) begin
        flush_pend <= 1'b1;
      end

      if (state == LOOKUP) begin
        if (we_q) begin
          valid_q[idx] <= 1'b1;
          data_q       <= wdata_q;
        end else if (hit) begin
          data_q <= bus.cache_rdatab_i;
          if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
        end
      end

      if (fill) begin
        valid_q[idx] <= 1'b1;
        data_q       <= bus.mem_rsp_data_i;
      end
    end
  end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized self-checking bench for cache_fill_ctrl. The environment emulates
// the dual-port cache (tag/data arrays that survive controller reset) and a
// backing memory; a line-level reference model predicts hit/miss, response
// data and the saturating counters (narrow counters so saturation is reached).
module tb_cache_fill_ctrl;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned CNT_MAX = 7;

  logic clk;
  logic reset_n;
  logic flush_i;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  cache_fill_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  cache_fill_ctrl #(
    .IDX_BITS  (2),
    .ADDR_WIDTH(8),
    .DATA_WIDTH(16),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush_i),
    .hit_count_o (hit_count),
    .miss_count_o(miss_count),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cache array emulation: not reset, so tag 0 matches everywhere at start.
  logic [5:0]  ctag  [4] = '{default: '0};
  logic [15:0] cdata [4] = '{default: '0};

  always_comb begin
    bus.cache_rdatab_i = cdata[bus.cache_addrb_o[1:0]];
    bus.cache_rhitb_i  = (ctag[bus.cache_addrb_o[1:0]] == bus.cache_addrb_o[7:2]);
  end

  always @(posedge clk) begin
    if (bus.cache_cea_o && bus.cache_we_o) begin
      ctag[bus.cache_addra_o[1:0]]  <= bus.cache_addra_o[7:2];
      cdata[bus.cache_addra_o[1:0]] <= bus.cache_wdata_o;
    end
  end

  // Backing memory and reference model.
  logic [15:0] bmem [int];
  bit          ref_valid [4];
  logic [5:0]  ref_tag   [4];
  logic [15:0] ref_data  [4];
  int          ref_hit;
  int          ref_miss;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_val(input logic [7:0] a);
    if (!bmem.exists(int'(a))) bmem[int'(a)] = 16'($urandom);
    return bmem[int'(a)];
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;
    ref_hit  = 0;
    ref_miss = 0;
  endtask

  task automatic ref_flush();
    for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic check_counters();
    check_eq("hit_count", 32'(hit_count), 32'(ref_hit));
    check_eq("miss_count", 32'(miss_count), 32'(ref_miss));
  endtask

  // One request end to end. Called and returns at a negedge.
  task automatic txn(input logic we, input logic [7:0] a, input logic [15:0] wd,
                     input int stall, input int rdly, input int hold, input bit fl);
    logic [1:0]  ix;
    logic [5:0]  tg;
    logic [15:0] exp_d;
    bit exp_hit, done, fl_arm, flushed;
    int lat, nreq, rc, st, guard;
    ix      = a[1:0];
    tg      = a[7:2];
    exp_hit = !we && ref_valid[ix] && (ref_tag[ix] == tg);
    exp_d   = we ? wd : (exp_hit ? ref_data[ix] : mem_val(a));

    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_we_i    = we;
    bus.req_wdata_i = we ? wd : 16'($urandom);
    #1;
    guard = 0;
    while (!bus.req_ready_o && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_eq("req_accept", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;

    lat = 1; nreq = 0; rc = -1; st = stall; done = 1'b0; fl_arm = 1'b0; flushed = 1'b0;
    while (!done && lat < 60) begin
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_req_ready_i = 1'b0;
      flush_i             = 1'b0;
      if (fl_arm) begin
        flush_i = 1'b1;
        fl_arm  = 1'b0;
        flushed = 1'b1;
      end
      if (bus.resp_valid_o) begin
        done = 1'b1;
      end else begin
        if (lat == 1 && we) begin
          check_eq("lookup_cwe", 32'({bus.cache_cea_o, bus.cache_we_o}), 32'h3);
          check_eq("lookup_caddr", 32'(bus.cache_addra_o), 32'(a));
          check_eq("lookup_cwdata", 32'(bus.cache_wdata_o), 32'(wd));
        end
        if (bus.mem_req_valid_o) begin
          check_eq("mreq_addr", 32'(bus.mem_req_addr_o), 32'(a));
          check_eq("mreq_we", 32'(bus.mem_req_we_o), 32'(we));
          if (we) check_eq("mreq_wdata", 32'(bus.mem_req_wdata_o), 32'(wd));
          if (st > 0) begin
            st--;
          end else begin
            bus.mem_req_ready_i = 1'b1;
            nreq++;
            if (!we) begin
              rc     = rdly;
              fl_arm = fl;
            end
          end
        end else if (rc == 0) begin
          bus.mem_rsp_valid_i = 1'b1;
          bus.mem_rsp_data_i  = mem_val(a);
          rc = -1;
          #1;
          check_eq("fill_cwe", 32'({bus.cache_cea_o, bus.cache_we_o}), 32'h3);
          check_eq("fill_caddr", 32'(bus.cache_addra_o), 32'(a));
          check_eq("fill_cwdata", 32'(bus.cache_wdata_o), 32'(mem_val(a)));
        end else if (rc > 0) begin
          rc--;
        end
        @(negedge clk);
        lat++;
      end
    end
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    flush_i             = 1'b0;
    check_eq("resp_seen", 32'(done), 32'd1);
    if (exp_hit) check_eq("hit_latency", 32'(lat), 32'd2);
    check_eq("mem_req_count", 32'(nreq), exp_hit ? 32'd0 : 32'd1);

    for (int h = 0; h < hold; h++) begin
      check_eq("resp_hold_valid", 32'(bus.resp_valid_o), 32'd1);
      check_eq("resp_hold_data", 32'(bus.resp_data_o), 32'(exp_d));
      @(negedge clk);
    end
    check_eq("resp_data", 32'(bus.resp_data_o), 32'(exp_d));
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    check_eq("resp_drop", 32'(bus.resp_valid_o), 32'd0);

    if (we) begin
      bmem[int'(a)] = wd;
    end else if (exp_hit) begin
      if (ref_hit < CNT_MAX) ref_hit++;
    end else begin
      if (ref_miss < CNT_MAX) ref_miss++;
    end
    if (!exp_hit) begin
      ref_valid[ix] = 1'b1;
      ref_tag[ix]   = tg;
      ref_data[ix]  = exp_d;
    end
    check_counters();
    if (flushed) begin
      ref_flush();
      check_eq("pend_flush_ready", 32'(bus.req_ready_o), 32'd0);
      @(negedge clk);
      check_eq("post_flush_ready", 32'(bus.req_ready_o), 32'd1);
    end
  endtask

  // Flush in IDLE with a competing request: flush wins, request not taken.
  task automatic idle_flush();
    flush_i         = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 8'($urandom);
    bus.req_we_i    = 1'b0;
    #1;
    check_eq("flush_blocks_ready", 32'(bus.req_ready_o), 32'd0);
    @(negedge clk);
    flush_i         = 1'b0;
    bus.req_valid_i = 1'b0;
    #1;
    check_eq("flush_no_accept", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    ref_flush();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    flush_i  = 1'b0;
    bus.req_valid_i     = 1'b0;
    bus.req_addr_i      = '0;
    bus.req_we_i        = 1'b0;
    bus.req_wdata_i     = '0;
    bus.resp_ready_i    = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
    ref_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check_eq("rst_resp_data", 32'(bus.resp_data_o), 32'd0);
    check_eq("rst_mreq_valid", 32'(bus.mem_req_valid_o), 32'd0);
    check_eq("rst_cache_en", 32'({bus.cache_cea_o, bus.cache_ceb_o, bus.cache_we_o}), 32'd0);
    check_counters();
    reset_n = 1'b1;
    @(negedge clk);

    // Directed scenarios.
    bmem[0] = 16'hBEEF;
    txn(1'b0, 8'h00, 16'h0, 0, 1, 0, 1'b0);     // stale tag match -> miss
    txn(1'b0, 8'h00, 16'h0, 0, 0, 0, 1'b0);     // hit, 2-cycle latency
    txn(1'b0, 8'h04, 16'h0, 0, 2, 0, 1'b0);     // evicts idx0
    txn(1'b0, 8'h00, 16'h0, 0, 0, 0, 1'b0);     // miss again
    check_eq("miss_count_3", 32'(miss_count), 32'd3);
    txn(1'b1, 8'h13, 16'h1234, 0, 0, 0, 1'b0);  // write-allocate, write-through
    txn(1'b0, 8'h13, 16'h0, 0, 0, 0, 1'b0);     // hit on written data
    txn(1'b0, 8'h21, 16'h0, 5, 3, 5, 1'b0);     // stalls on both handshakes
    txn(1'b0, 8'h02, 16'h0, 1, 2, 0, 1'b1);     // flush during MEM_WAIT
    txn(1'b0, 8'h00, 16'h0, 0, 0, 0, 1'b0);     // miss after flush
    idle_flush();

    // Reset while waiting on the memory response.
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 8'h08;
    bus.req_we_i    = 1'b0;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check_eq("rm_mreq", 32'(bus.mem_req_valid_o), 32'd1);
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    reset_n = 1'b0;
    #1;
    ref_reset();
    check_eq("rm_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check_eq("rm_cache_en", 32'({bus.cache_cea_o, bus.cache_ceb_o, bus.cache_we_o}), 32'd0);
    check_counters();
    @(negedge clk);
    reset_n = 1'b1;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 16'hDEAD;
    #1;
    check_eq("rm_late_rsp_cwe", 32'(bus.cache_cea_o), 32'd0);
    @(negedge clk);
    bus.mem_rsp_valid_i = 1'b0;
    check_eq("rm_no_resp", 32'(bus.resp_valid_o), 32'd0);
    check_eq("rm_idle_ready", 32'(bus.req_ready_o), 32'd1);

    // Randomized traffic; narrow counters saturate along the way.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 14) == 0) begin
        idle_flush();
      end else begin
        txn(1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 31)), 16'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
